// File: rtl/stoch_pkg.sv
// Shared definitions for the stochastic bitstream generator: FSM states,
// default comparator width and maximal-length Fibonacci LFSR tap masks.
package stoch_pkg;

    localparam int unsigned W_DEFAULT = 14;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    // Tap mask for a shift-left Fibonacci LFSR: bit (t-1) set for tap t.
    // Supported widths 2..16; each mask gives a period of 2**w - 1.
    function automatic logic [31:0] lfsr_taps(input int unsigned w);
        logic [31:0] m;
        case (w)
            2:       m = 32'h0000_0003;
            3:       m = 32'h0000_0006;
            4:       m = 32'h0000_000C;
            5:       m = 32'h0000_0014;
            6:       m = 32'h0000_0030;
            7:       m = 32'h0000_0060;
            8:       m = 32'h0000_00B8;
            9:       m = 32'h0000_0110;
            10:      m = 32'h0000_0240;
            11:      m = 32'h0000_0500;
            12:      m = 32'h0000_0829;
            13:      m = 32'h0000_100D;
            14:      m = 32'h0000_2015;
            15:      m = 32'h0000_6000;
            16:      m = 32'h0000_D008;
            default: m = 32'h0000_0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/stoch_lfsr.sv
// W-bit maximal-length Fibonacci LFSR with synchronous seed load and step enable.
module stoch_lfsr
    import stoch_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] seed,
    input  logic         en,
    output logic [W-1:0] state
);

    localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

    logic [W-1:0] state_q, state_d;
    logic         fb;

    always_comb begin
        fb      = ^(state_q & TAPS);
        state_d = state_q;
        if (load) begin
            state_d = seed;
        end else if (en) begin
            state_d = {state_q[W-2:0], fb};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= seed;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/stochastic_bitstream_gen.sv
// Unipolar stochastic number generator: emits 2**W bits whose ones count equals
// the (saturated) probability numerator, using a bit-reversed counter or an LFSR.
module stochastic_bitstream_gen
    import stoch_pkg::*;
#(
    parameter int unsigned   W         = W_DEFAULT,
    parameter logic [W-1:0]  LFSR_SEED = {{(W-1){1'b0}}, 1'b1}
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [W:0]   p_in,
    input  logic         mode,
    output logic         bit_valid,
    input  logic         bit_ready,
    output logic         bit_out,
    output logic         bit_last,
    output logic         done,
    output logic [W:0]   ones_count
);

    localparam logic [W:0]   P_MAX    = {1'b1, {W{1'b0}}};
    localparam logic [W-1:0] IDX_LAST = '1;

    state_e       state_q, state_d;
    logic [W:0]   p_q, p_d;
    logic [W:0]   ones_q, ones_d;
    logic         mode_q, mode_d;
    logic [W-1:0] idx_q, idx_d;
    logic         bit_valid_q, bit_valid_d;
    logic         start_ready_q, start_ready_d;
    logic         done_q, done_d;

    logic         lfsr_load;
    logic         lfsr_en;
    logic [W-1:0] lfsr_state;
    logic [W-1:0] idx_rev;
    logic [W-1:0] r_val;
    logic         is_last;
    logic         run;
    logic         bit_cmp;
    logic         beat_fire;

    stoch_lfsr #(.W(W)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (lfsr_load),
        .seed  (LFSR_SEED),
        .en    (lfsr_en),
        .state (lfsr_state)
    );

    always_comb begin
        idx_rev = '0;
        for (int unsigned i = 0; i < W; i++) begin
            idx_rev[i] = idx_q[W-1-i];
        end
    end

    // The LFSR never reaches zero, so the final beat substitutes r = 0 to make
    // the random source a full permutation of 0..2**W-1.
    always_comb begin
        run       = (state_q == ST_RUN);
        is_last   = (idx_q == IDX_LAST);
        r_val     = mode_q ? (is_last ? '0 : lfsr_state) : idx_rev;
        bit_cmp   = (p_q > {1'b0, r_val});
        beat_fire = bit_valid_q & bit_ready;
        lfsr_en   = beat_fire;
    end

    always_comb begin
        state_d       = state_q;
        p_d           = p_q;
        mode_d        = mode_q;
        idx_d         = idx_q;
        ones_d        = ones_q;
        bit_valid_d   = bit_valid_q;
        start_ready_d = start_ready_q;
        done_d        = 1'b0;
        lfsr_load     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_valid && start_ready_q) begin
                    p_d           = (p_in > P_MAX) ? P_MAX : p_in;
                    mode_d        = mode;
                    idx_d         = '0;
                    ones_d        = '0;
                    lfsr_load     = 1'b1;
                    bit_valid_d   = 1'b1;
                    start_ready_d = 1'b0;
                    state_d       = ST_RUN;
                end
            end
            ST_RUN: begin
                if (beat_fire) begin
                    idx_d  = idx_q + W'(1);
                    ones_d = ones_q + (W+1)'(bit_cmp);
                    if (is_last) begin
                        bit_valid_d = 1'b0;
                        done_d      = 1'b1;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                start_ready_d = 1'b1;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            p_q           <= '0;
            mode_q        <= 1'b0;
            idx_q         <= '0;
            ones_q        <= '0;
            bit_valid_q   <= 1'b0;
            start_ready_q <= 1'b1;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            p_q           <= p_d;
            mode_q        <= mode_d;
            idx_q         <= idx_d;
            ones_q        <= ones_d;
            bit_valid_q   <= bit_valid_d;
            start_ready_q <= start_ready_d;
            done_q        <= done_d;
        end
    end

    assign start_ready = start_ready_q;
    assign bit_valid   = bit_valid_q;
    assign bit_out     = run & bit_cmp;
    assign bit_last    = run & is_last;
    assign done        = done_q;
    assign ones_count  = ones_q;

endmodule

// File: tb/tb_stochastic_bitstream_gen.sv
// Scoreboard bench for stochastic_bitstream_gen: the driver queues expected beats
// and final counts, the monitor checks them on every accepted beat and done pulse.
module tb_stochastic_bitstream_gen;

    localparam int unsigned W = 14;
    localparam int unsigned N = 1 << W;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_valid;
    logic         start_ready;
    logic [W:0]   p_in;
    logic         mode;
    logic         bit_valid;
    logic         bit_ready = 1'b1;
    logic         bit_out;
    logic         bit_last;
    logic         done;
    logic [W:0]   ones_count;

    typedef struct packed {
        logic chk;
        logic b;
        logic last;
    } beat_t;

    beat_t       exp_q[$];
    int unsigned exp_ones_q[$];

    int          tests     = 0;
    int          fails     = 0;
    int          done_cnt  = 0;
    int          beat_cnt  = 0;
    int          and_ones  = 0;
    bit          and_en    = 1'b0;
    bit          bp_en     = 1'b0;
    bit          stalled   = 1'b0;
    logic        held_bit;
    logic        held_last;

    stochastic_bitstream_gen #(
        .W         (W),
        .LFSR_SEED (14'd1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .p_in        (p_in),
        .mode        (mode),
        .bit_valid   (bit_valid),
        .bit_ready   (bit_ready),
        .bit_out     (bit_out),
        .bit_last    (bit_last),
        .done        (done),
        .ones_count  (ones_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rev(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int k = 0; k < int'(W); k++) r[k] = v[W-1-k];
        return r;
    endfunction

    // Consumer: full-rate or 50% random backpressure, changed just after each edge.
    always @(posedge clk) begin
        #1;
        bit_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: samples on the falling edge, pops expectations on each handshake.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (start_valid && start_ready) begin
                beat_cnt = 0;
                and_ones = 0;
            end
            if (bit_valid) begin
                if (stalled) begin
                    check("stall_bit_out", 32'(bit_out), 32'(held_bit));
                    check("stall_bit_last", 32'(bit_last), 32'(held_last));
                end
                if (bit_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.chk) check("bit_out", 32'(bit_out), 32'(e.b));
                        check("bit_last", 32'(bit_last), 32'(e.last));
                    end
                    if (and_en && (beat_cnt % 2 == 0) && bit_out) and_ones++;
                    beat_cnt++;
                    stalled = 1'b0;
                end else begin
                    stalled   = 1'b1;
                    held_bit  = bit_out;
                    held_last = bit_last;
                end
            end else begin
                stalled = 1'b0;
            end
            if (done) begin
                done_cnt++;
                check("beats_per_stream", beat_cnt, N);
                if (exp_ones_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    check("ones_count_at_done", 32'(ones_count), exp_ones_q.pop_front());
                end
            end
        end
    end

    task automatic issue_start(input int unsigned p, input logic m);
        int unsigned budget = 0;
        while (!start_ready && budget < 100) begin
            @(posedge clk); #1;
            budget++;
        end
        check("start_ready_wait", 32'(start_ready), 32'd1);
        p_in        = (W+1)'(p);
        mode        = m;
        start_valid = 1'b1;
        @(posedge clk); #1;
        check("first_valid_latency", 32'(bit_valid), 32'd1);
        check("start_ready_low_in_run", 32'(start_ready), 32'd0);
    endtask

    task automatic push_expect(input int unsigned ps, input logic m);
        beat_t e;
        logic [W-1:0] iw;
        for (int unsigned i = 0; i < N; i++) begin
            iw     = i[W-1:0];
            e.chk  = (m == 1'b0) || (ps == 0) || (ps == N);
            e.b    = (m == 1'b0) ? (ps > 32'(rev(iw))) : (ps == N);
            e.last = (i == N - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic run_stream(input int unsigned p, input logic m, input bit bp, input bit hold);
        int unsigned ps = (p > N) ? N : p;
        int unsigned budget = 0;
        int          d0 = done_cnt;
        push_expect(ps, m);
        exp_ones_q.push_back(ps);
        bp_en = bp;
        issue_start(p, m);
        if (!hold) start_valid = 1'b0;
        while (!done && budget < 3 * N) begin
            @(posedge clk); #1;
            budget++;
        end
        start_valid = 1'b0;
        check("done_seen", 32'(done), 32'd1);
        bp_en = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("ones_count_held", 32'(ones_count), ps);
        check("single_done", done_cnt - d0, 32'd1);
        check("idle_after_done", 32'(start_ready), 32'd1);
        check("no_restart", 32'(bit_valid), 32'd0);
        check("expect_queue_drained", exp_q.size(), 32'd0);
        exp_q.delete();
        exp_ones_q.delete();
    endtask

    initial begin
        int unsigned budget;
        int          d0;
        int          diff;
        rst         = 1'b1;
        start_valid = 1'b0;
        p_in        = '0;
        mode        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_start_ready", 32'(start_ready), 32'd1);
        check("rst_bit_valid", 32'(bit_valid), 32'd0);
        check("rst_bit_out", 32'(bit_out), 32'd0);
        check("rst_bit_last", 32'(bit_last), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ones_count", 32'(ones_count), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Counter source at one half, start_valid held high throughout the run.
        run_stream(8192, 1'b0, 1'b0, 1'b1);

        // LFSR source at one quarter; product with the alternating half stream
        // (ones on even beats) should approach 1/8 within 0.02 probability error.
        and_en = 1'b1;
        run_stream(4096, 1'b1, 1'b0, 1'b0);
        and_en = 1'b0;
        diff = and_ones - 2048;
        if (diff < 0) diff = -diff;
        tests++;
        if (diff > int'(N / 50)) begin
            fails++;
            $display("FAIL and_product: got %0d ones expected 2048 +/- %0d", and_ones, N / 50);
        end

        // Abort a saturated stream at beat 100 with reset.
        push_expect(N, 1'b0);
        d0 = done_cnt;
        issue_start(20000, 1'b0);
        start_valid = 1'b0;
        budget = 0;
        while (beat_cnt < 100 && budget < 1000) begin
            @(posedge clk); #1;
            budget++;
        end
        check("reach_beat_100", 32'(beat_cnt >= 100), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_start_ready", 32'(start_ready), 32'd1);
        check("abort_bit_valid", 32'(bit_valid), 32'd0);
        check("abort_bit_last", 32'(bit_last), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_ones_count", 32'(ones_count), 32'd0);
        exp_q.delete();
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("abort_no_done", done_cnt - d0, 32'd0);

        // Fresh start under random backpressure, checked against the ideal sequence.
        run_stream(5000, 1'b0, 1'b1, 1'b0);

        // Zero probability through the LFSR source.
        run_stream(0, 1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
